// File: rtl/trng_sample_ctrl_if.sv
// Word output port of the TRNG sampler: producer drives data/valid, consumer drives ready.
// Transfer occurs on any cycle with word_valid && word_ready.
interface trng_sample_ctrl_if #(
  parameter int WORD_WIDTH = 32
) ();
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/trng_sample_ctrl.sv
// RO entropy sequencer: warm-up, divided sampling into words, repetition-count health lockout.
// Word valid 2 cycles after the last sample; words held stable while ready is low, no sampling meanwhile.
module trng_sample_ctrl #(
  parameter int WORD_WIDTH    = 32,
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               raw_bit,
  output logic               ro_enable,
  output logic               busy,
  output logic               health_fail,
  trng_sample_ctrl_if.master word_if
);

  localparam int WCW = $clog2(WARMUP_CYCLES + 1);
  localparam int DVW = $clog2(SAMPLE_DIV + 1);
  localparam int BCW = $clog2(WORD_WIDTH + 1);
  localparam int RCW = $clog2(REP_LIMIT + 1);

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(SAMPLE_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_WIDTH - 1);
  localparam logic [RCW-1:0] REP_MAX   = RCW'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD,
    S_FAIL
  } state_t;

  state_t         state, state_next;
  logic [WCW-1:0] warm_cnt;
  logic [DVW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [RCW-1:0] rep_cnt, rep_next;
  logic           prev_bit;
  logic           sample_now;
  logic           rep_trip;
  logic           handshake;

  assign sample_now = (state == S_COLLECT) && (div_cnt == DIV_LAST);
  assign handshake  = (state == S_HOLD) && word_if.word_valid && word_if.word_ready;
  assign rep_trip   = sample_now && (rep_next == REP_MAX);

  // rep_cnt == 0 marks the first sample after warm-up, which always starts a new run.
  always_comb begin
    rep_next = rep_cnt;
    if ((rep_cnt == '0) || (raw_bit != prev_bit)) begin
      rep_next = RCW'(1);
    end else if (rep_cnt != REP_MAX) begin
      rep_next = rep_cnt + RCW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && !stop) state_next = S_WARMUP;
      end
      S_WARMUP: begin
        if (stop)                         state_next = S_IDLE;
        else if (warm_cnt == WARM_LAST)   state_next = S_COLLECT;
      end
      S_COLLECT: begin
        // A failing sample locks out even if stop arrives in the same cycle.
        if (rep_trip)                              state_next = S_FAIL;
        else if (stop)                             state_next = S_IDLE;
        else if (sample_now && bit_cnt == BIT_LAST) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (stop)           state_next = S_IDLE;
        else if (handshake) state_next = S_COLLECT;
      end
      S_FAIL: begin
        state_next = S_FAIL;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= S_IDLE;
      ro_enable          <= 1'b0;
      busy               <= 1'b0;
      health_fail        <= 1'b0;
      word_if.word_valid <= 1'b0;
      word_if.word_data  <= '0;
      warm_cnt           <= '0;
      div_cnt            <= '0;
      bit_cnt            <= '0;
      rep_cnt            <= '0;
      prev_bit           <= 1'b0;
    end else begin
      state       <= state_next;
      ro_enable   <= (state_next == S_WARMUP) || (state_next == S_COLLECT) || (state_next == S_HOLD);
      busy        <= (state_next == S_WARMUP) || (state_next == S_COLLECT) || (state_next == S_HOLD);
      health_fail <= health_fail || (state_next == S_FAIL);
      // Valid rises one cycle after HOLD entry: W*DIV+2 cycles per word with ready held high.
      word_if.word_valid <= (state == S_HOLD) && (state_next == S_HOLD);

      warm_cnt <= (state == S_WARMUP) ? warm_cnt + WCW'(1) : '0;

      if (state == S_COLLECT) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DVW'(1);
      end else begin
        div_cnt <= '0;
      end

      if (sample_now) begin
        bit_cnt           <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BCW'(1);
        word_if.word_data <= {word_if.word_data[WORD_WIDTH-2:0], raw_bit};
        prev_bit          <= raw_bit;
        rep_cnt           <= rep_next;
      end else begin
        if (state != S_COLLECT) bit_cnt <= '0;
        if (state == S_WARMUP)  rep_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl with W=8, WARMUP=4, DIV=1, REP=6.
module tb_trng_sample_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic stop;
  logic raw_bit;
  logic ro_enable;
  logic busy;
  logic health_fail;
  int   n_tests = 0;
  int   n_fail  = 0;

  trng_sample_ctrl_if #(.WORD_WIDTH(8)) wif ();

  trng_sample_ctrl #(
    .WORD_WIDTH   (8),
    .WARMUP_CYCLES(4),
    .SAMPLE_DIV   (1),
    .REP_LIMIT    (6)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .raw_bit    (raw_bit),
    .ro_enable  (ro_enable),
    .busy       (busy),
    .health_fail(health_fail),
    .word_if    (wif)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Bits go in MSB first, one per cycle (DIV=1).
  task automatic feed_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      raw_bit = w[i];
      step();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_ro"},    ro_enable,      1'b0);
    chk1({tag, "_busy"},  busy,           1'b0);
    chk1({tag, "_valid"}, wif.word_valid, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    raw_bit        = 1'b0;
    wif.word_ready = 1'b0;
    step();
    step();
    chk_idle("rst");
    chk1("rst_health", health_fail, 1'b0);
    chk8("rst_data", wif.word_data, 8'h00);
    reset = 1'b0;

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk_idle("startstop");
    step();
    chk_idle("startstop2");

    // first word 0xB2 with ready held high
    wif.word_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("warm_ro", ro_enable, 1'b1);
    chk1("warm_busy", busy, 1'b1);
    repeat (4) step();
    chk1("warm_novalid", wif.word_valid, 1'b0);
    feed_word(8'hB2);
    chk1("hold_entry_valid", wif.word_valid, 1'b0);
    step();
    chk1("w1_valid", wif.word_valid, 1'b1);
    chk8("w1_data", wif.word_data, 8'hB2);
    step();
    chk1("w1_accepted", wif.word_valid, 1'b0);
    chk8("w1_data_kept", wif.word_data, 8'hB2);
    chk1("w1_busy", busy, 1'b1);

    // backpressure: word held 20 cycles while raw_bit toggles
    wif.word_ready = 1'b0;
    feed_word(8'h69);
    step();
    for (int i = 0; i < 20; i++) begin
      raw_bit = i[0];
      step();
      chk1("bp_valid", wif.word_valid, 1'b1);
      chk8("bp_data", wif.word_data, 8'h69);
    end
    wif.word_ready = 1'b1;
    step();
    chk1("bp_accepted", wif.word_valid, 1'b0);
    feed_word(8'hA5);
    step();
    chk1("w3_valid", wif.word_valid, 1'b1);
    chk8("w3_data", wif.word_data, 8'hA5);
    step();
    chk1("w3_accepted", wif.word_valid, 1'b0);

    // five 1s spanning a word boundary and HOLD, then a 0 restarts the run
    feed_word(8'h57);
    step();
    chk8("w4_data", wif.word_data, 8'h57);
    step();
    feed_word(8'hC1);
    step();
    chk1("w5_valid", wif.word_valid, 1'b1);
    chk8("w5_data", wif.word_data, 8'hC1);
    chk1("w5_health", health_fail, 1'b0);
    step();
    chk1("w5_accepted", wif.word_valid, 1'b0);

    // stop while holding an unaccepted word
    wif.word_ready = 1'b0;
    feed_word(8'hAA);
    step();
    chk1("w6_valid", wif.word_valid, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_idle("stop_hold");
    step();
    chk_idle("stop_hold2");

    // stop during warm-up
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("rewarm_ro", ro_enable, 1'b1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_idle("stop_warm");

    // restart: full warm-up, ones during warm-up must not be sampled
    raw_bit = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk1("rewarm_novalid", wif.word_valid, 1'b0);
    feed_word(8'h24);
    step();
    chk1("w7_valid", wif.word_valid, 1'b1);
    chk8("w7_data", wif.word_data, 8'h24);

    // reset while in HOLD
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("rst_hold");
    chk8("rst_hold_data", wif.word_data, 8'h00);
    chk1("rst_hold_health", health_fail, 1'b0);

    // stuck-at-1: trip on the 6th equal sample
    raw_bit = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    repeat (5) step();
    chk1("stuck5_health", health_fail, 1'b0);
    chk1("stuck5_busy", busy, 1'b1);
    step();
    chk1("stuck6_health", health_fail, 1'b1);
    chk_idle("stuck6");
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("fail_start_health", health_fail, 1'b1);
    chk1("fail_start_ro", ro_enable, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk1("fail_stop_health", health_fail, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("fail_reset_health", health_fail, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
